fire4_squeeze_ctrl: RTL and testbench
=====================================

// Module: fire4_squeeze_ctrl
// PURPOSE
//  Sequencer for the fire4 squeeze MAC array. Runs one full layer pass after start_i.
//  - Drives the array layer enable and the ifm buffer read address.
//  - Sees each pixel's sample pulse and turns it into an ofm buffer write.
//  - Stalls at pixel boundaries while the ofm buffer is full; reports done and layer feedback.
// PARAMETERS
//  WOUT   32   output feature map side; pixels per layer P = WOUT*WOUT
//  CHIN   128  input channels
//  KDIM   3    kernel side; MAC taps per pixel N = KDIM*KDIM*CHIN
//  ADDR_W $clog2(WOUT*WOUT*KDIM*KDIM*CHIN)  ifm read address width
//  OADR_W $clog2(WOUT*WOUT)                 ofm write address width
// PORTS
//  clk            in   1       clock, all flops rising edge
//  rst            in   1       asynchronous active-low reset
//  start_i        in   1       start pulse; honoured in IDLE or DONE only
//  ofm_ready_i    in   1       ofm buffer can take one more pixel
//  sample_i       in   1       array sample pulse, one per finished pixel
//  layer_en_o     out  1       enable to squeeze array (counts its internal tap counter)
//  ifm_addr_o     out  ADDR_W  ifm buffer read address
//  ofm_wr_en_o    out  1       ofm buffer write strobe
//  ofm_wr_addr_o  out  OADR_W  ofm buffer write address (pixel index)
//  busy_o         out  1       high in RUN, HOLD, DRAIN
//  done_o         out  1       high in DONE
//  ram_feedback_o out  1       one-cycle pulse on entry to DONE
//  err_o          out  1       sticky: sample_i outside RUN/HOLD/DRAIN or more than P samples
// BEHAVIOUR
//  Reset (async, rst=0): state IDLE. All counters 0. All outputs 0, including err_o.
//  Counters
//   - tap t: 0..N. t==N is the array clear cycle, so one pixel = N+1 enabled cycles.
//   - pixel p: 0..P-1.
//   - sample s: 0..P.
//  IDLE
//   - start_i -> RUN; t, p, s cleared.
//  RUN
//   - layer_en_o=1. t increments each cycle.
//   - ifm_addr_o = p*N + t (registered) for t<N; held at p*N+N-1 during t==N.
//   - On t==N with p==P-1 -> DRAIN, t=0.
//   - On t==N with p<P-1 -> p++, t=0. Then:
//       ofm_ready_i=1 -> stay RUN (no bubble between pixels);
//       ofm_ready_i=0 -> HOLD.
//  HOLD
//   - layer_en_o=0. t, p and ifm_addr_o frozen.
//   - ofm_ready_i=1 -> RUN on the next cycle.
//   - Pausing is legal only at pixel boundaries; mid-pixel the enable never drops.
//  DRAIN
//   - layer_en_o=0. Wait for outstanding samples.
//   - When s==P -> DONE.
//  DONE
//   - done_o=1; ram_feedback_o=1 for the entry cycle only.
//   - start_i -> RUN, restart at p=0; done_o drops the same edge.
//  Sample path
//   - sample_i in RUN/HOLD/DRAIN with s<P: next cycle ofm_wr_en_o=1 and ofm_wr_addr_o=s; then s++.
//   - Any other sample_i: no write; err_o=1 (cleared only by reset).
//   - sample_i in the same cycle as the RUN->HOLD or ->DRAIN transition is still captured.
//  start_i in RUN/HOLD/DRAIN: ignored, no error.
//  Reset mid-operation: state and counters clear immediately; no partial write issued.
//  Latency
//   - start_i to first layer_en_o: 1 cycle.
//   - sample_i to ofm_wr_en_o: 1 cycle.
//   - Last sample to done_o: 2 cycles (s update, then state).
//  Counter widths sized so N, P and P*N never wrap; compares use the full count.
// TESTING (bench params WOUT=2, CHIN=2, KDIM=1 -> N=2, P=4; array model pulses sample_i 3 cycles after t==N)
//  1 Nominal: start_i, ofm_ready_i=1.
//    -> layer_en_o high 12 consecutive cycles; ifm_addr_o 0,1,1,2,3,3,4,5,5,6,7,7.
//    -> 4 writes, addr 0..3; done_o and one ram_feedback_o pulse; err_o=0.
//  2 Backpressure: ofm_ready_i=0 for 5 cycles at the first boundary.
//    -> layer_en_o low exactly 5 cycles; ifm_addr_o held at 2.
//    -> write sequence unchanged; total enabled cycles still 12.
//  3 Stray sample: sample_i in IDLE -> no ofm_wr_en_o, err_o=1.
//    Inject a 5th sample in DRAIN of a run -> err_o stays 1, exactly 4 writes.
//  4 start_i asserted while busy -> ignored, ifm_addr_o sequence as in 1.
//    start_i in DONE -> restart, second pass identical, second ram_feedback_o pulse.
//  5 Reset mid-run: rst low during RUN at p=2 -> all outputs 0 asynchronously.
//    After release and start_i -> clean pass from address 0.
//  6 Full-size (32/128/3): 1153*1024 enabled cycles.
//    -> last ifm_addr_o 1179647, 1024 writes, done_o once.

Source files
------------

// File: rtl/fire4_squeeze_ctrl_if.sv
// Control/handshake bundle between the fire4 squeeze sequencer, the MAC array,
// the ifm/ofm buffers and the layer scheduler.
interface fire4_squeeze_ctrl_if #(
    parameter int ADDR_W = 21,
    parameter int OADR_W = 10
);
    logic              start_i;
    logic              ofm_ready_i;
    logic              sample_i;
    logic              layer_en_o;
    logic [ADDR_W-1:0] ifm_addr_o;
    logic              ofm_wr_en_o;
    logic [OADR_W-1:0] ofm_wr_addr_o;
    logic              busy_o;
    logic              done_o;
    logic              ram_feedback_o;
    logic              err_o;

    modport slave (
        input  start_i, ofm_ready_i, sample_i,
        output layer_en_o, ifm_addr_o, ofm_wr_en_o, ofm_wr_addr_o,
               busy_o, done_o, ram_feedback_o, err_o
    );

    modport master (
        output start_i, ofm_ready_i, sample_i,
        input  layer_en_o, ifm_addr_o, ofm_wr_en_o, ofm_wr_addr_o,
               busy_o, done_o, ram_feedback_o, err_o
    );
endinterface

// File: rtl/fire4_squeeze_ctrl.sv
// Layer-pass sequencer for the fire4 squeeze MAC array: walks taps/pixels,
// issues ifm reads, turns array sample pulses into ofm writes.
module fire4_squeeze_ctrl #(
    parameter int WOUT   = 32,
    parameter int CHIN   = 128,
    parameter int KDIM   = 3,
    parameter int ADDR_W = $clog2(WOUT*WOUT*KDIM*KDIM*CHIN),
    parameter int OADR_W = $clog2(WOUT*WOUT)
) (
    input  logic                 clk,
    input  logic                 rst,
    fire4_squeeze_ctrl_if.slave  bus
);
    localparam int N     = KDIM*KDIM*CHIN;
    localparam int P     = WOUT*WOUT;
    localparam int TAP_W = $clog2(N+1);
    localparam int PIX_W = $clog2(P+1);
    localparam int SMP_W = $clog2(P+1);

    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(N);
    localparam logic [TAP_W-1:0] TAP_HOLD = TAP_W'(N-1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(P-1);
    localparam logic [SMP_W-1:0] SMP_FULL = SMP_W'(P);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_HOLD, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [TAP_W-1:0]    tap_q, tap_d;
    logic [PIX_W-1:0]    pix_q, pix_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [SMP_W-1:0]    smp_q;
    logic                fb_q, fb_d;
    logic                err_q;
    logic                start_acc;
    logic                active;
    logic                vld_p1;
    logic [OADR_W-1:0]   wr_addr_p1;

    assign active = (state_q == S_RUN) || (state_q == S_HOLD) || (state_q == S_DRAIN);

    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        pix_d     = pix_q;
        addr_d    = addr_q;
        start_acc = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start_i) begin
                    start_acc = 1'b1;
                    state_d   = S_RUN;
                    tap_d     = '0;
                    pix_d     = '0;
                    addr_d    = '0;
                end
            end
            S_RUN: begin
                if (tap_q == TAP_LAST) begin
                    // clear cycle: step to the next pixel base, pause only here
                    tap_d = '0;
                    if (pix_q == PIX_LAST) begin
                        state_d = S_DRAIN;
                    end else begin
                        pix_d  = pix_q + PIX_W'(1);
                        addr_d = addr_q + ADDR_W'(1);
                        if (!bus.ofm_ready_i) state_d = S_HOLD;
                    end
                end else begin
                    tap_d = tap_q + TAP_W'(1);
                    if (tap_q != TAP_HOLD) addr_d = addr_q + ADDR_W'(1);
                end
            end
            S_HOLD: begin
                if (bus.ofm_ready_i) state_d = S_RUN;
            end
            S_DRAIN: begin
                if (smp_q == SMP_FULL) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        fb_d = (state_d == S_DONE) && (state_q != S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            tap_q   <= '0;
            pix_q   <= '0;
            addr_q  <= '0;
            fb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            pix_q   <= pix_d;
            addr_q  <= addr_d;
            fb_q    <= fb_d;
        end
    end

    // p0 -> p1: accepted sample becomes an ofm write one cycle later
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            smp_q      <= '0;
            vld_p1     <= 1'b0;
            wr_addr_p1 <= '0;
            err_q      <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            if (bus.sample_i) begin
                if (active && (smp_q != SMP_FULL)) begin
                    vld_p1     <= 1'b1;
                    wr_addr_p1 <= smp_q[OADR_W-1:0];
                    smp_q      <= smp_q + SMP_W'(1);
                end else begin
                    err_q <= 1'b1;
                end
            end
            if (start_acc) smp_q <= '0;
        end
    end

    assign bus.layer_en_o     = (state_q == S_RUN);
    assign bus.ifm_addr_o     = addr_q;
    assign bus.ofm_wr_en_o    = vld_p1;
    assign bus.ofm_wr_addr_o  = wr_addr_p1;
    assign bus.busy_o         = active;
    assign bus.done_o         = (state_q == S_DONE);
    assign bus.ram_feedback_o = fb_q;
    assign bus.err_o          = err_q;
endmodule

// File: tb/tb_fire4_squeeze_ctrl.sv
// Scoreboard bench for fire4_squeeze_ctrl with a small layer (N=2 taps, P=4 pixels)
// and a behavioural array that pulses sample_i three cycles after each pixel's clear cycle.
module tb_fire4_squeeze_ctrl;
    localparam int WOUT   = 2;
    localparam int CHIN   = 2;
    localparam int KDIM   = 1;
    localparam int N      = KDIM*KDIM*CHIN;
    localparam int P      = WOUT*WOUT;
    localparam int ADDR_W = $clog2(P*N);
    localparam int OADR_W = $clog2(P);

    logic clk = 1'b0;
    logic rst = 1'b1;

    fire4_squeeze_ctrl_if #(.ADDR_W(ADDR_W), .OADR_W(OADR_W)) bus();

    fire4_squeeze_ctrl #(
        .WOUT(WOUT), .CHIN(CHIN), .KDIM(KDIM), .ADDR_W(ADDR_W), .OADR_W(OADR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int aq[$];
    int wq[$];
    int due[$];
    bit exp_err = 1'b0;
    bit started = 1'b0;
    int s_model = 0;
    int tapcnt  = 0;
    int en_cnt  = 0;
    int cyc     = 0;
    bit start_req = 1'b0;
    bit start_acc_m = 1'b0;
    bit stray_req = 1'b0;
    bit ready = 1'b1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: array model, sample legality, start model, then drive.
    task automatic tick();
        bit smp;
        @(negedge clk);
        cyc++;
        if (bus.layer_en_o) begin
            tapcnt++;
            en_cnt++;
            if (tapcnt == N+1) begin
                tapcnt = 0;
                due.push_back(cyc + 3);
            end
        end
        if (start_req && start_acc_m) begin
            started = 1'b1;
            s_model = 0;
            tapcnt  = 0;
            en_cnt  = 0;
            for (int k = 0; k < P*(N+1); k++) begin
                int t;
                t = k % (N+1);
                aq.push_back((k / (N+1)) * N + ((t < N) ? t : N-1));
            end
        end
        smp = 1'b0;
        if (due.size() > 0 && due[0] == cyc) begin
            void'(due.pop_front());
            smp = 1'b1;
        end
        if (stray_req) smp = 1'b1;
        if (smp) begin
            if (started && s_model < P) begin
                wq.push_back(s_model);
                s_model++;
            end else begin
                exp_err = 1'b1;
            end
        end
        bus.sample_i    = smp;
        bus.start_i     = start_req;
        bus.ofm_ready_i = ready;
        start_req = 1'b0;
        stray_req = 1'b0;
    endtask

    task automatic start_pulse(input bit accept);
        start_req   = 1'b1;
        start_acc_m = accept;
        tick();
    endtask

    task automatic do_reset(input int hold);
        #2 rst = 1'b0;
        aq.delete();
        wq.delete();
        due.delete();
        started = 1'b0;
        s_model = 0;
        tapcnt  = 0;
        exp_err = 1'b0;
        #1 chk("async_reset_outputs",
               {bus.layer_en_o, bus.ifm_addr_o, bus.ofm_wr_en_o, bus.ofm_wr_addr_o,
                bus.busy_o, bus.done_o, bus.ram_feedback_o, bus.err_o}, 0);
        repeat (hold) tick();
        rst = 1'b1;
    endtask

    task automatic wait_done(input bit rnd, input bit stray_drain);
        bit got = 1'b0;
        bit inj = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            if (rnd) begin
                ready = ($urandom_range(0, 2) != 0);
                if (s_model < P && $urandom_range(0, 15) == 0) begin
                    start_req   = 1'b1;
                    start_acc_m = 1'b0;
                end
            end
            if (stray_drain && !inj && s_model == P) begin
                stray_req = 1'b1;
                inj = 1'b1;
            end
            tick();
            got = bus.done_o;
        end
        ready = 1'b1;
        chk("done_reached", got, 1);
    endtask

    // Monitor: predicts enable from the pass rules and pops the scoreboards.
    initial begin
        int  kdone = 0;
        bit  last_en = 1'b0;
        bit  done_due = 1'b0;
        bit  in_rst = 1'b0;
        int  nwr = 0;
        bit  rdy_in;
        bit  exp_en;
        int  a;
        forever begin
            @(posedge clk);
            rdy_in = bus.ofm_ready_i;
            #1;
            if (!rst) begin
                if (!in_rst)
                    chk("reset_outputs",
                        {bus.layer_en_o, bus.ifm_addr_o, bus.ofm_wr_en_o, bus.ofm_wr_addr_o,
                         bus.busy_o, bus.done_o, bus.ram_feedback_o, bus.err_o}, 0);
                in_rst = 1'b1;
                kdone = 0;
                last_en = 1'b0;
                done_due = 1'b0;
                nwr = 0;
                continue;
            end
            in_rst = 1'b0;

            if (aq.size() == 0)      exp_en = 1'b0;
            else if (kdone == 0)     exp_en = 1'b1;
            else if (last_en)        exp_en = !((((kdone-1) % (N+1)) == N) && !rdy_in);
            else                     exp_en = rdy_in;
            chk("layer_en", bus.layer_en_o, exp_en);
            if (bus.layer_en_o && aq.size() > 0) begin
                a = aq.pop_front();
                chk("ifm_addr", bus.ifm_addr_o, a);
                chk("busy_in_run", bus.busy_o, 1);
                kdone++;
                if (aq.size() == 0) kdone = 0;
            end
            last_en = bus.layer_en_o;

            if (done_due) begin
                chk("done_after_last_write", bus.done_o, 1);
                chk("ram_feedback_entry", bus.ram_feedback_o, 1);
                chk("busy_in_done", bus.busy_o, 0);
                chk("writes_per_pass", nwr, P);
                nwr = 0;
                done_due = 1'b0;
            end else begin
                chk("ram_feedback_idle", bus.ram_feedback_o, 0);
            end

            if (bus.ofm_wr_en_o) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", bus.ofm_wr_en_o, 0);
                end else begin
                    a = wq.pop_front();
                    chk("ofm_wr_addr", bus.ofm_wr_addr_o, a);
                    nwr++;
                    if (a == P-1) done_due = 1'b1;
                end
            end

            chk("err", bus.err_o, exp_err);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t reached without finishing, expected finish earlier", $time);
        $fatal(1);
    end

    initial begin
        bus.start_i     = 1'b0;
        bus.ofm_ready_i = 1'b1;
        bus.sample_i    = 1'b0;
        do_reset(3);

        // nominal pass with an ignored start while busy
        start_pulse(1'b1);
        repeat (4) tick();
        start_pulse(1'b0);
        wait_done(1'b0, 1'b0);
        tick();

        // restart from DONE with 5 cycles of backpressure at the first boundary
        start_pulse(1'b1);
        tick();
        tick();
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i >= 1) begin
                chk("hold_layer_en", bus.layer_en_o, 0);
                chk("hold_ifm_addr", bus.ifm_addr_o, 2);
            end
        end
        ready = 1'b1;
        wait_done(1'b0, 1'b0);

        // randomized backpressure and stray starts
        repeat (3) begin
            tick();
            start_pulse(1'b1);
            wait_done(1'b1, 1'b0);
        end

        // reset in the middle of pixel 2
        tick();
        start_pulse(1'b1);
        for (int i = 0; i < 50 && en_cnt < 2*(N+1)+1; i++) tick();
        do_reset(3);

        // stray sample in IDLE, then a clean pass with err held
        stray_req = 1'b1;
        tick();
        tick();
        chk("err_sticky_idle", bus.err_o, 1);
        chk("idle_not_busy", bus.busy_o, 0);
        start_pulse(1'b1);
        wait_done(1'b0, 1'b0);

        // extra sample in DRAIN after all pixels were sampled
        tick();
        start_pulse(1'b1);
        wait_done(1'b0, 1'b1);
        chk("err_after_drain_stray", bus.err_o, 1);

        // reset clears err; final random pass
        do_reset(2);
        start_pulse(1'b1);
        wait_done(1'b1, 1'b0);
        repeat (4) tick();
        chk("addr_scoreboard_left", aq.size(), 0);
        chk("write_scoreboard_left", wq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
